// File: rtl/fifo_cfg_pkg.sv
// Shared definitions for the async-FIFO configuration register bank:
// register addresses, bit positions, reset values and the threshold clamp.
package fifo_cfg_pkg;

    typedef enum logic [2:0] {
        ADDR_CTRL     = 3'd0,
        ADDR_AF_THR   = 3'd1,
        ADDR_AE_THR   = 3'd2,
        ADDR_STATUS   = 3'd3,
        ADDR_LEVEL    = 3'd4,
        ADDR_EVENTS   = 3'd5,
        ADDR_IRQ_MASK = 3'd6,
        ADDR_ID       = 3'd7
    } reg_addr_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_AF_BIT     = 2;
    localparam int STAT_AE_BIT     = 3;

    localparam int EVT_OVF_BIT     = 0;
    localparam int EVT_UNF_BIT     = 1;
    localparam int EVT_W           = 2;

    // Flush is a write-only pulse, so only the persistent CTRL bits are stored.
    typedef struct packed {
        logic irq_en;
        logic enable;
    } ctrl_t;

    function automatic int unsigned af_thr_rst(input int unsigned asize);
        return (32'd1 << asize) - 32'd2;
    endfunction

    function automatic int unsigned ae_thr_rst(input int unsigned asize);
        return (asize > 0) ? 32'd2 : 32'd0;
    endfunction

    // Thresholds beyond a completely full FIFO are meaningless; pin them to full.
    function automatic int unsigned thr_clamp(input int unsigned value, input int unsigned asize);
        int unsigned lim;
        lim = 32'd1 << asize;
        return (value > lim) ? lim : value;
    endfunction

endpackage

// File: rtl/fifo_cfg_evt.sv
// One sticky event bit: set by a pulse, cleared by a write-1, set wins on collision.
// Single-cycle update, no backpressure.
module fifo_cfg_evt (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else if (clr) begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_cfg_regs.sv
// Config/status register bank for the async FIFO write side; reads return one cycle after the strobe.
// One access per cycle at full throughput, never backpressures; flags and irq are registered.
module fifo_cfg_regs
    import fifo_cfg_pkg::*;
#(
    parameter int               ASIZE    = 4,
    parameter int               CSIZE    = 16,
    parameter int               CAWD     = 3,
    parameter logic [CSIZE-1:0] ID_VALUE = CSIZE'(16'hF1F0)
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             cfg_wr,
    input  logic             cfg_rd,
    input  logic [CAWD-1:0]  cfg_addr,
    input  logic [CSIZE-1:0] cfg_wdata,
    output logic [CSIZE-1:0] cfg_rdata,
    output logic             cfg_rvalid,
    output logic             cfg_err,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [ASIZE:0]   fifo_level,
    input  logic             ovf_pulse,
    input  logic             unf_pulse,
    output logic             fifo_enable,
    output logic             fifo_flush,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             irq
);

    localparam int             LW     = ASIZE + 1;
    localparam logic [LW-1:0]  AF_RST = LW'(af_thr_rst(ASIZE));
    localparam logic [LW-1:0]  AE_RST = LW'(ae_thr_rst(ASIZE));

    ctrl_t              ctrl;
    logic [LW-1:0]      af_thr;
    logic [LW-1:0]      ae_thr;
    logic [EVT_W-1:0]   irq_mask;
    logic [EVT_W-1:0]   evt_q;
    logic [EVT_W-1:0]   evt_set;
    logic [EVT_W-1:0]   evt_clr;

    reg_addr_e          addr;
    logic               addr_hi;
    logic               is_ro;
    logic               acc_err;
    logic               wr_ok;
    logic               rd_ok;
    logic [LW-1:0]      thr_wdata;
    logic [CSIZE-1:0]   rd_mux;

    assign addr = reg_addr_e'(cfg_addr[2:0]);

    generate
        if (CAWD > 3) begin : g_addr_hi
            assign addr_hi = |cfg_addr[CAWD-1:3];
        end else begin : g_no_addr_hi
            assign addr_hi = 1'b0;
        end
    endgenerate

    // Any error suppresses the whole access, including a simultaneous read.
    always_comb begin
        is_ro   = (addr == ADDR_STATUS) || (addr == ADDR_LEVEL) || (addr == ADDR_ID);
        acc_err = (cfg_wr | cfg_rd) & ((cfg_wr & cfg_rd) | addr_hi | (cfg_wr & is_ro));
        wr_ok   = cfg_wr & ~cfg_rd & ~addr_hi & ~is_ro;
        rd_ok   = cfg_rd & ~cfg_wr & ~addr_hi;
    end

    // Clamp is applied to the full write word before narrowing to the register width.
    assign thr_wdata = LW'(thr_clamp(32'(cfg_wdata), ASIZE));

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN_BIT]     = ctrl.enable;
                rd_mux[CTRL_IRQ_EN_BIT] = ctrl.irq_en;
            end
            ADDR_AF_THR:   rd_mux[LW-1:0] = af_thr;
            ADDR_AE_THR:   rd_mux[LW-1:0] = ae_thr;
            ADDR_STATUS: begin
                rd_mux[STAT_FULL_BIT]  = fifo_full;
                rd_mux[STAT_EMPTY_BIT] = fifo_empty;
                rd_mux[STAT_AF_BIT]    = almost_full;
                rd_mux[STAT_AE_BIT]    = almost_empty;
            end
            ADDR_LEVEL:    rd_mux[LW-1:0]    = fifo_level;
            ADDR_EVENTS:   rd_mux[EVT_W-1:0] = evt_q;
            ADDR_IRQ_MASK: rd_mux[EVT_W-1:0] = irq_mask;
            ADDR_ID:       rd_mux            = ID_VALUE;
            default:       rd_mux            = '0;
        endcase
    end

    always_comb begin
        evt_set                = '0;
        evt_set[EVT_OVF_BIT]   = ovf_pulse;
        evt_set[EVT_UNF_BIT]   = unf_pulse;
        evt_clr                = '0;
        if (wr_ok && (addr == ADDR_EVENTS)) begin
            evt_clr = cfg_wdata[EVT_W-1:0];
        end
    end

    fifo_cfg_evt u_evt_ovf (
        .clk (wclk),
        .rst (wrst),
        .set (evt_set[EVT_OVF_BIT]),
        .clr (evt_clr[EVT_OVF_BIT]),
        .q   (evt_q[EVT_OVF_BIT])
    );

    fifo_cfg_evt u_evt_unf (
        .clk (wclk),
        .rst (wrst),
        .set (evt_set[EVT_UNF_BIT]),
        .clr (evt_clr[EVT_UNF_BIT]),
        .q   (evt_q[EVT_UNF_BIT])
    );

    always_ff @(posedge wclk) begin
        if (wrst) begin
            ctrl         <= '0;
            af_thr       <= AF_RST;
            ae_thr       <= AE_RST;
            irq_mask     <= '0;
            cfg_rdata    <= '0;
            cfg_rvalid   <= 1'b0;
            cfg_err      <= 1'b0;
            fifo_flush   <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            irq          <= 1'b0;
        end else begin
            cfg_rvalid <= rd_ok;
            cfg_err    <= acc_err;
            fifo_flush <= wr_ok && (addr == ADDR_CTRL) && cfg_wdata[CTRL_FLUSH_BIT];
            if (rd_ok) begin
                cfg_rdata <= rd_mux;
            end
            if (wr_ok) begin
                case (addr)
                    ADDR_CTRL: begin
                        ctrl.enable <= cfg_wdata[CTRL_EN_BIT];
                        ctrl.irq_en <= cfg_wdata[CTRL_IRQ_EN_BIT];
                    end
                    ADDR_AF_THR:   af_thr   <= thr_wdata;
                    ADDR_AE_THR:   ae_thr   <= thr_wdata;
                    ADDR_IRQ_MASK: irq_mask <= cfg_wdata[EVT_W-1:0];
                    default: ;
                endcase
            end
            almost_full  <= (fifo_level >= af_thr);
            almost_empty <= (fifo_level <= ae_thr);
            irq          <= ctrl.irq_en & (|(evt_q & irq_mask));
        end
    end

    assign fifo_enable = ctrl.enable;

endmodule

// File: tb/tb_fifo_cfg_regs.sv
// Randomised scoreboard bench for fifo_cfg_regs (ASIZE=4, CSIZE=16, CAWD=4).
module tb_fifo_cfg_regs;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        cfg_wr;
    logic        cfg_rd;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        cfg_rvalid;
    logic        cfg_err;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_level;
    logic        ovf_pulse;
    logic        unf_pulse;
    logic        fifo_enable;
    logic        fifo_flush;
    logic        almost_full;
    logic        almost_empty;
    logic        irq;

    fifo_cfg_regs #(
        .ASIZE (4),
        .CSIZE (16),
        .CAWD  (4)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .cfg_wr       (cfg_wr),
        .cfg_rd       (cfg_rd),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .cfg_rvalid   (cfg_rvalid),
        .cfg_err      (cfg_err),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .ovf_pulse    (ovf_pulse),
        .unf_pulse    (unf_pulse),
        .fifo_enable  (fifo_enable),
        .fifo_flush   (fifo_flush),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .irq          (irq)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        bit          rvalid;
        bit          err;
        bit          en;
        bit          flush;
        bit          af;
        bit          ae;
        bit          irq;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: architectural register contents, as seen by software.
    bit          m_en, m_irq_en, m_af, m_ae;
    int          m_af_thr, m_ae_thr;
    bit [1:0]    m_ev, m_mask;
    logic [15:0] m_rdata;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input int a);
        case (a)
            0: return 16'(m_en) | (16'(m_irq_en) << 2);
            1: return 16'(m_af_thr);
            2: return 16'(m_ae_thr);
            3: return 16'(fifo_full) | (16'(fifo_empty) << 1) | (16'(m_af) << 2) | (16'(m_ae) << 3);
            4: return 16'(fifo_level);
            5: return 16'(m_ev);
            6: return 16'(m_mask);
            7: return 16'hF1F0;
            default: return 16'h0;
        endcase
    endfunction

    // Predict the outputs after the coming edge from the driven inputs, then advance one cycle.
    task automatic tick();
        exp_t     e;
        int       a, lvl, wv;
        bit       wr, rd, ro, is_err, wr_ok;
        bit [1:0] clr;
        a   = int'(cfg_addr);
        lvl = int'(fifo_level);
        wr  = cfg_wr;
        rd  = cfg_rd;
        if (wrst) begin
            m_en = 0; m_irq_en = 0; m_af_thr = 14; m_ae_thr = 2;
            m_ev = 0; m_mask = 0; m_af = 0; m_ae = 1; m_rdata = 16'h0;
            e = '{rvalid: 0, err: 0, en: 0, flush: 0, af: 0, ae: 1, irq: 0, rdata: 16'h0};
        end else begin
            ro     = (a == 3) || (a == 4) || (a == 7);
            is_err = (wr || rd) && ((wr && rd) || (a >= 8) || (wr && ro));
            wr_ok  = wr && !is_err;
            e.rvalid = rd && !is_err;
            e.err    = is_err;
            if (e.rvalid) m_rdata = model_read(a);
            e.rdata = m_rdata;
            e.flush = wr_ok && (a == 0) && cfg_wdata[1];
            e.irq   = m_irq_en && ((m_ev & m_mask) != 2'b00);
            e.af    = lvl >= m_af_thr;
            e.ae    = lvl <= m_ae_thr;
            clr     = (wr_ok && a == 5) ? cfg_wdata[1:0] : 2'b00;
            wv      = int'(cfg_wdata);
            if (wr_ok) begin
                case (a)
                    0: begin m_en = cfg_wdata[0]; m_irq_en = cfg_wdata[2]; end
                    1: m_af_thr = (wv > 16) ? 16 : wv;
                    2: m_ae_thr = (wv > 16) ? 16 : wv;
                    6: m_mask = cfg_wdata[1:0];
                    default: ;
                endcase
            end
            m_ev = (m_ev & ~clr) | {unf_pulse, ovf_pulse};
            m_af = e.af;
            m_ae = e.ae;
            e.en = m_en;
        end
        sb.push_back(e);
        @(negedge wclk);
        #1;
        cfg_wr = 0; cfg_rd = 0; ovf_pulse = 0; unf_pulse = 0;
    endtask

    task automatic wr_reg(input int a, input logic [15:0] d);
        cfg_wr = 1; cfg_addr = 4'(a); cfg_wdata = d;
        tick();
    endtask

    task automatic rd_reg(input int a);
        cfg_rd = 1; cfg_addr = 4'(a);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_level(input int l);
        fifo_level = 5'(l);
        fifo_full  = (l == 16);
        fifo_empty = (l == 0);
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rvalid",       16'(cfg_rvalid),   16'(e.rvalid));
                check("err",          16'(cfg_err),      16'(e.err));
                check("rdata",        cfg_rdata,         e.rdata);
                check("fifo_enable",  16'(fifo_enable),  16'(e.en));
                check("fifo_flush",   16'(fifo_flush),   16'(e.flush));
                check("almost_full",  16'(almost_full),  16'(e.af));
                check("almost_empty", 16'(almost_empty), 16'(e.ae));
                check("irq",          16'(irq),          16'(e.irq));
            end
        end
    end

    initial begin
        int op, a;
        wrst = 1; cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0;
        ovf_pulse = 0; unf_pulse = 0;
        set_level(0);
        @(negedge wclk);
        #1;

        // Reset defaults
        idle(3);
        wrst = 0;
        idle(2);
        for (int i = 0; i < 8; i++) rd_reg(i);

        // Thresholds and clamp
        wr_reg(1, 16'd10);
        set_level(9);
        idle(2);
        set_level(10);
        idle(2);
        wr_reg(1, 16'd40);
        rd_reg(1);
        rd_reg(3);

        // Flush, including back-to-back pulses
        wr_reg(0, 16'b011);
        idle(1);
        rd_reg(0);
        wr_reg(0, 16'b011);
        wr_reg(0, 16'b011);
        idle(1);

        // Events and interrupt, with set/clear collision
        wr_reg(6, 16'd1);
        wr_reg(0, 16'b101);
        ovf_pulse = 1;
        tick();
        idle(2);
        rd_reg(5);
        cfg_wr = 1; cfg_addr = 4'd5; cfg_wdata = 16'd1; ovf_pulse = 1;
        tick();
        rd_reg(5);
        wr_reg(5, 16'd1);
        idle(3);
        unf_pulse = 1;
        tick();
        rd_reg(5);

        // Errors: wr+rd, write to RO, illegal address
        cfg_wr = 1; cfg_rd = 1; cfg_addr = 4'd0; cfg_wdata = 16'h0;
        tick();
        wr_reg(3, 16'hFFFF);
        rd_reg(9);
        wr_reg(12, 16'h0005);
        rd_reg(0);
        rd_reg(6);

        // Reset during back-to-back reads
        for (int i = 0; i < 8; i++) begin
            wrst = (i == 3) || (i == 4);
            cfg_rd = 1; cfg_addr = 4'(i);
            tick();
        end
        wrst = 0;
        for (int i = 0; i < 8; i++) rd_reg(i);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            wrst = ($urandom_range(0, 99) == 0);
            set_level($urandom_range(0, 16));
            ovf_pulse = ($urandom_range(0, 7) == 0);
            unf_pulse = ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 19);
            a  = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            cfg_addr  = 4'(a);
            cfg_wdata = (a == 1 || a == 2) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            if (op < 7) begin
                cfg_wr = 1;
            end else if (op < 15) begin
                cfg_rd = 1;
            end else if (op == 15) begin
                cfg_wr = 1; cfg_rd = 1;
            end
            tick();
        end
        wrst = 0;
        idle(2);

        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
